// File: rtl/crc_checker_if.sv
// Beat input and verdict output channels of the CRC checker.
// The master modport is the stream source and verdict consumer; the slave modport is the checker.
interface crc_checker_if #(
  parameter int unsigned CRC_SIZE   = 8,
  parameter int unsigned FRAME_SIZE = 8
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [FRAME_SIZE-1:0] in_data;
  logic                  in_last;
  logic [CRC_SIZE-1:0]   in_crc;

  logic                  res_valid;
  logic                  res_ready;
  logic                  res_pass;
  logic [CRC_SIZE-1:0]   res_crc;

  modport master (
    output in_valid, in_data, in_last, in_crc, res_ready,
    input  in_ready, res_valid, res_pass, res_crc
  );

  modport slave (
    input  in_valid, in_data, in_last, in_crc, res_ready,
    output in_ready, res_valid, res_pass, res_crc
  );

endinterface

// File: rtl/crc_checker.sv
// Receive-side CRC checker: recomputes a run-time configurable CRC over a framed beat
// stream, compares it with the CRC carried on the last beat and counts frames and failures.
module crc_checker #(
  parameter int unsigned CRC_SIZE   = 8,
  parameter int unsigned FRAME_SIZE = 8,
  parameter int unsigned CNT_SIZE   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CRC_SIZE-1:0] cfg_poly,
  input  logic [CRC_SIZE-1:0] cfg_init,
  input  logic [CRC_SIZE-1:0] cfg_poly_size,
  input  logic                cnt_clear,
  output logic [CNT_SIZE-1:0] frame_cnt,
  output logic [CNT_SIZE-1:0] err_cnt,
  crc_checker_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;

  state_t              state;
  logic [CRC_SIZE-1:0] crc_q;
  logic [CRC_SIZE-1:0] poly_q;
  logic [CRC_SIZE-1:0] mask_q;

  logic [CRC_SIZE-1:0] cfg_mask_c;
  logic [CRC_SIZE-1:0] src_crc_c;
  logic [CRC_SIZE-1:0] src_poly_c;
  logic [CRC_SIZE-1:0] src_mask_c;
  logic [CRC_SIZE-1:0] fold_c;
  logic                beat_c;
  logic                fail_c;

  // One beat folded MSB first; every intermediate value stays inside the active width.
  function automatic logic [CRC_SIZE-1:0] crc_fold(
    input logic [CRC_SIZE-1:0]   crc_in,
    input logic [FRAME_SIZE-1:0] data,
    input logic [CRC_SIZE-1:0]   poly,
    input logic [CRC_SIZE-1:0]   mask
  );
    logic [CRC_SIZE-1:0]   crc;
    logic [CRC_SIZE-1:0]   top;
    logic [FRAME_SIZE-1:0] d;
    logic                  fb;
    top = mask & ~(mask >> 1);
    crc = crc_in & mask;
    d   = data;
    for (int unsigned i = 0; i < FRAME_SIZE; i++) begin
      fb  = (|(crc & top)) ^ d[FRAME_SIZE-1];
      crc = (crc << 1) & mask;
      if (fb) crc = crc ^ (poly & mask);
      d   = d << 1;
    end
    return crc;
  endfunction

  // First beat of a frame works from the live config, later beats from the latched copy.
  always_comb begin
    cfg_mask_c = cfg_poly_size | CRC_SIZE'(1);
    src_crc_c  = crc_q;
    src_poly_c = poly_q;
    src_mask_c = mask_q;
    if (state == IDLE) begin
      src_crc_c  = cfg_init & cfg_mask_c;
      src_poly_c = cfg_poly;
      src_mask_c = cfg_mask_c;
    end
    fold_c = crc_fold(src_crc_c, bus.in_data, src_poly_c, src_mask_c);
    beat_c = bus.in_valid & bus.in_ready;
    fail_c = |((fold_c ^ bus.in_crc) & src_mask_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      crc_q         <= '0;
      poly_q        <= '0;
      mask_q        <= '0;
      bus.in_ready  <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_pass  <= 1'b0;
      bus.res_crc   <= '0;
      frame_cnt     <= '0;
      err_cnt       <= '0;
    end else begin
      if (cnt_clear) begin
        frame_cnt <= '0;
        err_cnt   <= '0;
      end
      case (state)
        IDLE, ACCUM: begin
          if (beat_c) begin
            crc_q  <= fold_c;
            poly_q <= src_poly_c;
            mask_q <= src_mask_c;
            if (bus.in_last) begin
              state         <= RESULT;
              bus.in_ready  <= 1'b0;
              bus.res_valid <= 1'b1;
              bus.res_crc   <= fold_c;
              bus.res_pass  <= ~fail_c;
              // A same-cycle clear wins over the increment.
              if (!cnt_clear) begin
                if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + CNT_SIZE'(1);
                if (fail_c && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_SIZE'(1);
              end
            end else begin
              state <= ACCUM;
            end
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.res_valid <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_checker.sv
// Self-checking bench for crc_checker: directed vectors plus random frames checked against
// a polynomial long-division reference model.
module tb_crc_checker;

  localparam int unsigned CW  = 16;
  localparam int unsigned FW  = 8;
  localparam int unsigned NW  = 4;
  localparam int          CMX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_poly;
  logic [CW-1:0] cfg_init;
  logic [CW-1:0] cfg_poly_size;
  logic          cnt_clear;
  logic [NW-1:0] frame_cnt;
  logic [NW-1:0] err_cnt;

  crc_checker_if #(.CRC_SIZE(CW), .FRAME_SIZE(FW)) bus ();

  crc_checker #(.CRC_SIZE(CW), .FRAME_SIZE(FW), .CNT_SIZE(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_poly     (cfg_poly),
    .cfg_init     (cfg_init),
    .cfg_poly_size(cfg_poly_size),
    .cnt_clear    (cnt_clear),
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;
  int exp_errs = 0;

  logic [7:0]  m[$];
  logic [7:0]  q2[$];
  logic [15:0] ecrc;
  logic [15:0] rx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC = (I*x^L + M*x^N) mod (x^N + poly), by modulo-2 long division on a bit array.
  function automatic logic [15:0] ref_crc(input logic [7:0] msg[$], input int n,
                                           input logic [15:0] poly, input logic [15:0] init);
    int          l;
    bit          a[];
    logic [15:0] r;
    l = msg.size() * 8;
    a = new[l + n];
    for (int i = 0; i < l; i++) a[i] = msg[i / 8][7 - (i % 8)];
    for (int j = 0; j < n; j++) a[j] = a[j] ^ init[n - 1 - j];
    for (int i = 0; i < l; i++) begin
      if (a[i]) begin
        a[i] = 1'b0;
        for (int j = 0; j < n; j++) a[i + 1 + j] = a[i + 1 + j] ^ poly[n - 1 - j];
      end
    end
    r = '0;
    for (int j = 0; j < n; j++) r[n - 1 - j] = a[l + j];
    return r;
  endfunction

  function automatic void bump(input logic pass, input bit clr);
    if (clr) begin
      exp_frames = 0;
      exp_errs   = 0;
    end else begin
      if (exp_frames < CMX) exp_frames++;
      if (!pass && exp_errs < CMX) exp_errs++;
    end
  endfunction

  task automatic send_frame(input string tag, input logic [7:0] msg[$], input logic [15:0] rxc,
                            input bit scramble, input bit clr);
    int n;
    for (int i = 0; i < msg.size(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = msg[i];
      bus.in_last  = (i == msg.size() - 1);
      bus.in_crc   = bus.in_last ? rxc : 16'($urandom);
      cnt_clear    = clr && bus.in_last;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (n == 20) check({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      if (scramble && i == 0) begin
        cfg_poly      = 16'($urandom);
        cfg_init      = 16'($urandom);
        cfg_poly_size = 16'($urandom);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    cnt_clear    = 1'b0;
    check({tag, "_latency"}, 32'(bus.res_valid), 32'd1);
  endtask

  task automatic get_result(input string tag, input logic [15:0] exp_crc, input logic exp_pass,
                            input bit clr, input bit has_const, input logic [15:0] const_crc);
    int n;
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_res_crc"}, 32'(bus.res_crc), 32'(exp_crc));
    check({tag, "_res_pass"}, 32'(bus.res_pass), 32'(exp_pass));
    if (has_const) check({tag, "_known_crc"}, 32'(bus.res_crc), 32'(const_crc));
    bump(exp_pass, clr);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_errs));
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check({tag, "_res_valid_drop"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] msg[$], input int n,
                           input logic [15:0] poly, input logic [15:0] init, input logic [15:0] rxc,
                           input bit scramble, input bit clr, input bit has_const,
                           input logic [15:0] const_crc);
    int          ne;
    logic [15:0] mask;
    logic [15:0] exp_crc;
    logic        exp_pass;
    ne            = (n == 0) ? 1 : n;
    mask          = 16'((32'd1 << ne) - 32'd1);
    cfg_poly      = poly;
    cfg_init      = init;
    cfg_poly_size = (n == 0) ? 16'h0 : mask;
    exp_crc       = ref_crc(msg, ne, poly, init);
    exp_pass      = ((exp_crc ^ rxc) & mask) == 16'h0;
    send_frame(tag, msg, rxc, scramble, clr);
    get_result(tag, exp_crc, exp_pass, clr, has_const, const_crc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cnt_clear = 1'b0;
    cfg_poly = '0;
    cfg_init = '0;
    cfg_poly_size = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.in_crc = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_pass", 32'(bus.res_pass), 32'd0);
    check("rst_res_crc", 32'(bus.res_crc), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // CRC-16/CCITT-FALSE over "123456789", good then corrupted received CRC
    m.delete();
    for (int i = 1; i <= 9; i++) m.push_back(8'(8'h30 + i));
    run_frame("ccitt_good", m, 16, 16'h1021, 16'hFFFF, 16'h29B1, 1'b0, 1'b0, 1'b1, 16'h29B1);
    run_frame("ccitt_bad", m, 16, 16'h1021, 16'hFFFF, 16'h29B0, 1'b0, 1'b0, 1'b1, 16'h29B1);

    // CRC-8 on the 16-bit instance; upper received bits ignored, config scrambled mid-frame
    run_frame("crc8_narrow", m, 8, 16'h0007, 16'h0000, 16'hABF4, 1'b1, 1'b0, 1'b1, 16'h00F4);

    // Verdict held while res_ready stays low; offered beat must not be consumed
    m.delete();
    q2.delete();
    for (int i = 0; i < 2; i++) m.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) q2.push_back(8'($urandom));
    cfg_poly = 16'h8005;
    cfg_init = 16'h0000;
    cfg_poly_size = 16'hFFFF;
    ecrc = ref_crc(m, 16, 16'h8005, 16'h0000);
    send_frame("stall", m, ecrc, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = q2[0];
      bus.in_last  = 1'b0;
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_res_valid", 32'(bus.res_valid), 32'd1);
      check("stall_res_crc", 32'(bus.res_crc), 32'(ecrc));
      check("stall_res_pass", 32'(bus.res_pass), 32'd1);
      @(posedge clk); #1;
    end
    bump(1'b1, 1'b0);
    check("stall_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("stall_release_ready", 32'(bus.in_ready), 32'd1);
    check("stall_release_valid", 32'(bus.res_valid), 32'd0);
    rx = ref_crc(q2, 16, 16'h8005, 16'h0000);
    run_frame("after_stall", q2, 16, 16'h8005, 16'h0000, rx, 1'b0, 1'b0, 1'b0, 16'h0);

    // Single-beat frame
    m.delete();
    m.push_back(8'h00);
    run_frame("single_beat", m, 8, 16'h0007, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000);

    // Random frames, including the illegal zero width treated as one bit
    for (int k = 0; k < 12; k++) begin
      int n;
      int len;
      logic [15:0] p;
      logic [15:0] iv;
      len = int'($urandom_range(1, 6));
      n   = (k == 5) ? 0 : int'($urandom_range(1, 16));
      p   = 16'($urandom);
      iv  = 16'($urandom);
      m.delete();
      for (int j = 0; j < len; j++) m.push_back(8'($urandom));
      rx = ($urandom_range(0, 3) == 0) ? ref_crc(m, (n == 0) ? 1 : n, p, iv) : 16'($urandom);
      run_frame("random", m, n, p, iv, rx, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 16'h0);
    end

    // Both counters driven into saturation
    for (int k = 0; k < 16; k++) begin
      m.delete();
      m.push_back(8'($urandom));
      rx = ref_crc(m, 8, 16'h0007, 16'h0000) ^ 16'h0001;
      run_frame("saturate", m, 8, 16'h0007, 16'h0000, rx, 1'b0, 1'b0, 1'b0, 16'h0);
    end
    check("sat_frame_cnt", 32'(frame_cnt), 32'(CMX));
    check("sat_err_cnt", 32'(err_cnt), 32'(CMX));

    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    exp_frames = 0;
    exp_errs = 0;
    check("clear_frame_cnt", 32'(frame_cnt), 32'd0);
    check("clear_err_cnt", 32'(err_cnt), 32'd0);

    // One good frame to make counters nonzero, then reset mid-frame discards the partial frame
    m.delete();
    for (int i = 1; i <= 9; i++) m.push_back(8'(8'h30 + i));
    run_frame("pre_reset", m, 16, 16'h1021, 16'hFFFF, 16'h29B1, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = m[i];
      bus.in_last  = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_frames = 0;
    exp_errs = 0;
    check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    run_frame("post_reset", m, 16, 16'h1021, 16'hFFFF, 16'h29B1, 1'b0, 1'b0, 1'b1, 16'h29B1);
    check("post_reset_count", 32'(frame_cnt), 32'd1);

    // Clear coinciding with a failing frame's increment
    run_frame("clear_vs_inc", m, 16, 16'h1021, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0);
    check("clr_inc_frame_cnt", 32'(frame_cnt), 32'd0);
    check("clr_inc_err_cnt", 32'(err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc_checker.md
Name: crc_checker

Overview:
- Receive-side counterpart of the parallel CRC generator.
- Accepts a framed stream of data beats, recomputes the CRC over the frame with a run-time programmable polynomial, width and init value, and compares it against the CRC received with the last beat.
- Returns a pass/fail verdict per frame over a valid/ready result channel.
- Keeps saturating frame and error counters for the register block.

Parameters:
- CRC_SIZE, 8: maximum CRC width in bits; the physical width of all CRC/config buses.
- FRAME_SIZE, 8: data bits per input beat.
- CNT_SIZE, 16: width of the frame and error counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_poly  input  CRC_SIZE  polynomial without implicit x^N term, LSB-aligned.
- cfg_init  input  CRC_SIZE  initial CRC value, LSB-aligned.
- cfg_poly_size  input  CRC_SIZE  thermometer mask; ones in bits [N-1:0] select active width N (1..CRC_SIZE).
- in_valid  input  1  data beat valid.
- in_ready  output  1  checker can accept a beat.
- in_data  input  FRAME_SIZE  data beat, processed MSB first.
- in_last  input  1  marks final beat of the frame.
- in_crc  input  CRC_SIZE  received CRC, LSB-aligned; sampled only on the accepted last beat.
- res_valid  output  1  verdict available.
- res_ready  input  1  consumer accepts verdict.
- res_pass  output  1  1 = computed CRC equals received CRC over active bits.
- res_crc  output  CRC_SIZE  computed CRC, bits above N forced to 0.
- cnt_clear  input  1  synchronous clear of both counters.
- frame_cnt  output  CNT_SIZE  frames checked, saturating.
- err_cnt  output  CNT_SIZE  frames failed, saturating.

Behaviour:
- Beat transfer occurs when in_valid & in_ready; result transfer occurs when res_valid & res_ready.
- FSM states: IDLE, ACCUM, RESULT.
- IDLE: in_ready=1. On an accepted beat:
  - latch cfg_poly, cfg_poly_size, and cfg_init & mask;
  - fold the beat into the latched init.
  - If in_last: go to RESULT. Otherwise go to ACCUM.
- ACCUM: in_ready=1. Each accepted beat is folded into the running CRC. An accepted in_last beat goes to RESULT.
- RESULT: in_ready=0, res_valid=1, outputs held stable. On res_ready go to IDLE; no same-cycle new beat.
- Config changes are ignored mid-frame; only the values latched at the first beat are used.
- Per-bit fold, FRAME_SIZE times per beat, MSB first:
  - fb = crc[N-1] ^ d;
  - crc = (crc << 1) & mask;
  - if fb, crc ^= poly & mask.
  - No reflection, no final XOR.
  - Implemented as a combinational unrolled chain; one beat per clock.
- Latency: res_valid asserts the cycle after the last beat is accepted.
- res_pass = ((crc_final ^ in_crc) & mask) == 0. Bits of in_crc above N are ignored.
- Single-beat frame: valid; first and last beat handled in the same cycle.
- Counters update on entry to RESULT: frame_cnt+1, and err_cnt+1 if fail. Both saturate at all-ones.
- cnt_clear has priority over an increment in the same cycle; the counters read 0 after that cycle.
- Reset values: state IDLE, in_ready=1, res_valid=0, res_pass=0, res_crc=0, frame_cnt=0, err_cnt=0.
- Reset mid-frame or while in RESULT: the partial frame or pending verdict is discarded with no counter update.
- cfg_poly_size = 0 is illegal; behaviour is unspecified, but the checker must not hang (treat as N=1).

Test Plan:
- CRC_SIZE=16, FRAME_SIZE=8; poly 0x1021, init 0xFFFF, mask 0xFFFF; frame "123456789" (9 beats), in_crc 0x29B1 -> res_crc 0x29B1, res_pass=1, frame_cnt=1, err_cnt=0.
- Same frame with in_crc 0x29B0 -> res_pass=0, err_cnt=1.
- Same instance, mask 0x00FF, poly 0x07, init 0x00, "123456789", in_crc 0xABF4 -> res_crc 0x00F4, res_pass=1 (upper bits ignored).
- res_ready held low 5 cycles in RESULT -> in_ready=0 and outputs stable throughout; a beat offered with in_valid=1 is not consumed; the next frame starts the cycle after the handshake.
- Single-beat frame 0x00, CRC-8 poly 0x07 init 0x00, in_crc 0x00 -> pass one cycle after the beat.
- rst pulsed after 4 of 9 beats, then a full good frame -> one pass verdict, frame_cnt=1; cnt_clear asserted together with the increment -> both counters 0.
